ctech_lib_cdc_toggle_tx: RTL

CTECH_LIB_CDC_TOGGLE_TX -- requirements
Module: ctech_lib_cdc_toggle_tx

---
 rtl/ctech_lib_cdc_toggle_tx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ctech_lib_cdc_toggle_tx.sv
// ctech_lib_cdc_toggle_tx
//   Source side of a toggle-handshake clock-domain crossing. A word offered
//   on in_valid/in_data is captured onto tx_data. One cycle later tx_req
//   toggles. The transfer completes once the synchronised tx_ack matches
//   tx_req. tx_data stays stable from capture until completion, so the
//   destination may sample it after it sees the req toggle.
//
// Parameters
//   WIDTH          data word width
//   SYNC_STAGES    tx_ack synchroniser depth, 2..4
//   TIMEOUT_CYCLES WAIT_ACK cycle limit (timeout build only)
//
// Ports
//   clk, rst       source clock, synchronous active-high reset
//   in_valid/in_data/in_ready   source-side valid/ready word input
//   tx_data, tx_req             held data bus and toggle request to dest
//   tx_ack                      toggle acknowledge from dest (asynchronous)
//   done                        one-cycle pulse on transfer completion
//   timeout_err                 sticky WAIT_ACK timeout flag (timeout build)
//
// Build option
//   CTECH_LIB_CDC_TOGGLE_TX_TIMEOUT_EN : adds the WAIT_ACK cycle counter and
//   the timeout_err port. The transfer is never aborted by a timeout.

module ctech_lib_cdc_toggle_tx #(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             done
`ifdef CTECH_LIB_CDC_TOGGLE_TX_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;

  state_t                 r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_tx_req, w_tx_req_n;
  logic [WIDTH-1:0]       r_tx_data;
  logic                   w_ack_s, w_ready, w_load, w_done;

  // tx_ack is only ever observed through this chain.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], tx_ack};
  end

  assign w_ack_s = r_sync[SYNC_STAGES-1];

  // A mismatch in IDLE is a stale ack from before a reset. No new word is
  // taken until the destination side settles back to our req level.
  assign w_ready = !rst && (r_state == IDLE) && (w_ack_s == r_tx_req);

  always_comb begin
    w_state_n  = r_state;
    w_tx_req_n = r_tx_req;
    w_load     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && w_ready) begin
          w_load    = 1'b1;
          w_state_n = SETUP;
        end
      end
      // Data went out on the previous edge. The toggle follows one cycle
      // later so the bus settles before the request.
      SETUP: begin
        w_tx_req_n = ~r_tx_req;
        w_state_n  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (w_ack_s == r_tx_req) begin
          w_done    = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx_req  <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_state  <= w_state_n;
      r_tx_req <= w_tx_req_n;
      if (w_load) r_tx_data <= in_data;
    end
  end

  assign in_ready = w_ready;
  assign tx_data  = r_tx_data;
  assign tx_req   = r_tx_req;
  // A reset cycle aborts the transfer, so it must not report completion.
  assign done     = w_done && !rst;

`ifdef CTECH_LIB_CDC_TOGGLE_TX_TIMEOUT_EN
  localparam int               CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]    TO_MAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_to_cnt, w_to_cnt_n;
  logic          r_to_err;

  // The count includes the current cycle: it is 1 in the first WAIT_ACK
  // cycle. It saturates at the limit and drops to 0 outside WAIT_ACK.
  always_comb begin
    w_to_cnt_n = '0;
    if (w_state_n == WAIT_ACK) begin
      if (r_state != WAIT_ACK)  w_to_cnt_n = CW'(1);
      else if (r_to_cnt != TO_MAX) w_to_cnt_n = r_to_cnt + 1'b1;
      else                      w_to_cnt_n = r_to_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_n;
      if (w_state_n == WAIT_ACK && w_to_cnt_n == TO_MAX) r_to_err <= 1'b1;
    end
  end

  assign timeout_err = r_to_err;
`endif

endmodule
